key_history_display: RTL and testbench

- Downstream consumer of the keypad scanner's confirmed-press output (one-hot row, synchronized col, single-cycle en).
- Decodes each confirmed press to a 4-bit hex code and shifts it into a two-digit history: the newest key goes to the right digit, the previous key to the left digit.
- Time-multiplexes one shared active-low seven-segment bus across both digits, with a blanking gap at every digit switch to prevent ghosting.

---
 rtl/kp_pkg.sv | 46 ++++
 rtl/seven_seg_font.sv | 31 +++
 rtl/key_history_display.sv | 132 +++++++++++++
 tb/tb_key_history_display.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/kp_pkg.sv
// Shared types, constants and keypad decode for the keypad display path.
package kp_pkg;

    typedef enum logic [1:0] {SHOW_R, BLANK_R, SHOW_L, BLANK_L} mux_state_t;

    localparam logic [6:0] SEG_OFF = 7'h7F;

    typedef struct packed {
        logic       valid;
        logic [3:0] code;
    } key_dec_t;

    function automatic logic onehot4(input logic [3:0] v);
        return (v != 4'b0000) && ((v & (v - 4'd1)) == 4'b0000);
    endfunction

    // The row/col encoders are only meaningful when both inputs are one-hot.
    function automatic key_dec_t kp_decode(input logic [3:0] row, input logic [3:0] col);
        key_dec_t   d;
        logic [1:0] r;
        logic [1:0] c;
        d.valid = onehot4(row) && onehot4(col);
        r       = {row[3] | row[2], row[3] | row[1]};
        c       = {col[3] | col[2], col[3] | col[1]};
        case ({r, c})
            4'b0000: d.code = 4'h1;
            4'b0001: d.code = 4'h2;
            4'b0010: d.code = 4'h3;
            4'b0011: d.code = 4'hA;
            4'b0100: d.code = 4'h4;
            4'b0101: d.code = 4'h5;
            4'b0110: d.code = 4'h6;
            4'b0111: d.code = 4'hB;
            4'b1000: d.code = 4'h7;
            4'b1001: d.code = 4'h8;
            4'b1010: d.code = 4'h9;
            4'b1011: d.code = 4'hC;
            4'b1100: d.code = 4'hE;
            4'b1101: d.code = 4'h0;
            4'b1110: d.code = 4'hF;
            default: d.code = 4'hD;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/seven_seg_font.sv
// Hex digit to active-low seven-segment glyph, segment order {g,f,e,d,c,b,a}.
module seven_seg_font
    import kp_pkg::*;
(
    input  logic [3:0] hex_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_OFF;
        case (hex_i)
            4'h0: seg_o = 7'h40;
            4'h1: seg_o = 7'h79;
            4'h2: seg_o = 7'h24;
            4'h3: seg_o = 7'h30;
            4'h4: seg_o = 7'h19;
            4'h5: seg_o = 7'h12;
            4'h6: seg_o = 7'h02;
            4'h7: seg_o = 7'h78;
            4'h8: seg_o = 7'h00;
            4'h9: seg_o = 7'h10;
            4'hA: seg_o = 7'h08;
            4'hB: seg_o = 7'h03;
            4'hC: seg_o = 7'h46;
            4'hD: seg_o = 7'h21;
            4'hE: seg_o = 7'h06;
            default: seg_o = 7'h0E;
        endcase
    end

endmodule

// File: rtl/key_history_display.sv
// Two-digit key history fed by the keypad scanner, multiplexed onto one
// active-low seven-segment bus with a blanking gap at each digit switch.
module key_history_display
    import kp_pkg::*;
#(
    parameter int unsigned MUX_DIV   = 48_000,
    parameter int unsigned BLANK_CYC = 480
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] row,
    input  logic [3:0] col,
    input  logic       en,
    output logic [6:0] seg,
    output logic [1:0] an,
    output logic       key_valid,
    output logic       key_err,
    output logic [3:0] last_key
);

    localparam int unsigned    CW         = $clog2(MUX_DIV);
    localparam logic [CW-1:0] SHOW_LAST  = CW'(MUX_DIV - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYC - 1);

    mux_state_t    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic [3:0] new_q, old_q, last_q;
    logic       new_v_q, old_v_q;
    logic       valid_q, err_q;
    logic [6:0] seg_q, seg_d;
    logic [1:0] an_q, an_d;

    key_dec_t   dec;
    logic [3:0] font_hex;
    logic [6:0] font_seg;

    always_comb dec = kp_decode(row, col);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            new_q   <= '0;
            old_q   <= '0;
            new_v_q <= 1'b0;
            old_v_q <= 1'b0;
            last_q  <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            valid_q <= en && dec.valid;
            err_q   <= en && !dec.valid;
            if (en && dec.valid) begin
                old_q   <= new_q;
                old_v_q <= new_v_q;
                new_q   <= dec.code;
                new_v_q <= 1'b1;
                last_q  <= dec.code;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= BLANK_L;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        logic last;
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        last    = ((state_q == SHOW_R) || (state_q == SHOW_L)) ? (cnt_q == SHOW_LAST)
                                                               : (cnt_q == BLANK_LAST);
        if (last) begin
            cnt_d = '0;
            case (state_q)
                SHOW_R:  state_d = BLANK_R;
                BLANK_R: state_d = SHOW_L;
                SHOW_L:  state_d = BLANK_L;
                default: state_d = SHOW_R;
            endcase
        end
    end

    // One font decoder serves both digits; the slot selects its input.
    assign font_hex = (state_q == SHOW_L) ? old_q : new_q;

    seven_seg_font u_font (
        .hex_i (font_hex),
        .seg_o (font_seg)
    );

    always_comb begin
        an_d  = 2'b00;
        seg_d = SEG_OFF;
        case (state_q)
            SHOW_R: begin
                an_d  = 2'b01;
                seg_d = new_v_q ? font_seg : SEG_OFF;
            end
            SHOW_L: begin
                an_d  = 2'b10;
                seg_d = old_v_q ? font_seg : SEG_OFF;
            end
            default: begin
                an_d  = 2'b00;
                seg_d = SEG_OFF;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            seg_q <= SEG_OFF;
            an_q  <= 2'b00;
        end else begin
            seg_q <= seg_d;
            an_q  <= an_d;
        end
    end

    assign seg       = seg_q;
    assign an        = an_q;
    assign key_valid = valid_q;
    assign key_err   = err_q;
    assign last_key  = last_q;

endmodule

// File: tb/tb_key_history_display.sv
// Self-checking bench for key_history_display with short mux timing.
module tb_key_history_display;

    localparam int unsigned M = 12;
    localparam int unsigned B = 3;
    localparam int unsigned P = 2 * (M + B);

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] row, col;
    logic       en;
    logic [6:0] seg;
    logic [1:0] an;
    logic       key_valid, key_err;
    logic [3:0] last_key;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic       v;
        logic       e;
        logic [3:0] k;
    } exp_t;

    exp_t       sb[$];
    logic [3:0] exp_last = 4'h0;

    logic [3:0] keymap [16] = '{4'h1, 4'h2, 4'h3, 4'hA, 4'h4, 4'h5, 4'h6, 4'hB,
                                4'h7, 4'h8, 4'h9, 4'hC, 4'hE, 4'h0, 4'hF, 4'hD};
    logic [6:0] glyph  [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    int unsigned s_cnt;
    logic [1:0]  exp_an;

    key_history_display #(.MUX_DIV(M), .BLANK_CYC(B)) dut (
        .clk       (clk),
        .reset     (reset),
        .row       (row),
        .col       (col),
        .en        (en),
        .seg       (seg),
        .an        (an),
        .key_valid (key_valid),
        .key_err   (key_err),
        .last_key  (last_key)
    );

    always #5 clk = ~clk;

    // Slot timeline from reset release: BLANK_L, SHOW_R, BLANK_R, SHOW_L.
    function automatic logic [1:0] an_at(input int unsigned s);
        int unsigned p;
        p = s % P;
        if (p < B)               return 2'b00;
        else if (p < B + M)      return 2'b01;
        else if (p < 2 * B + M)  return 2'b00;
        else                     return 2'b10;
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            s_cnt  <= 0;
            exp_an <= 2'b00;
        end else begin
            exp_an <= an_at(s_cnt);
            s_cnt  <= s_cnt + 1;
        end
    end

    function automatic exp_t expect_press(input logic [3:0] r, input logic [3:0] c,
                                          input logic [3:0] prev);
        exp_t x;
        int   ri = 0;
        int   ci = 0;
        x.v = ($countones(r) == 1) && ($countones(c) == 1);
        x.e = !x.v;
        x.k = prev;
        for (int i = 0; i < 4; i++) begin
            if (r[i]) ri = i;
            if (c[i]) ci = i;
        end
        if (x.v) x.k = keymap[ri * 4 + ci];
        return x;
    endfunction

    task automatic test_reset();
        reset = 1'b0; en = 1'b0; row = 4'h0; col = 4'h0;
        repeat (3) @(negedge clk);
        tests++;
        if (an !== 2'b00 || seg !== 7'h7F || key_valid !== 1'b0 || key_err !== 1'b0 || last_key !== 4'h0) begin
            fails++;
            $display("FAIL reset_state: an=%b seg=%h kv=%b ke=%b last=%h, expected an=00 seg=7f kv=0 ke=0 last=0",
                     an, seg, key_valid, key_err, last_key);
        end
        reset = 1'b1;
    endtask

    task automatic test_idle();
        for (int i = 0; i < int'(P) + 4; i++) begin
            @(negedge clk);
            tests++;
            if (an !== exp_an || seg !== 7'h7F || key_valid !== 1'b0 || key_err !== 1'b0) begin
                fails++;
                $display("FAIL idle_mux cyc %0d: an=%b seg=%h kv=%b ke=%b, expected an=%b seg=7f kv=0 ke=0",
                         i, an, seg, key_valid, key_err, exp_an);
            end
        end
    endtask

    task automatic test_press(input string name, input logic [3:0] r, input logic [3:0] c);
        exp_t x, got;
        @(negedge clk);
        en = 1'b1; row = r; col = c;
        x = expect_press(r, c, exp_last);
        exp_last = x.k;
        sb.push_back(x);
        @(negedge clk);
        en = 1'b0; row = 4'h0; col = 4'h0;
        got = sb.pop_front();
        tests++;
        if (key_valid !== got.v || key_err !== got.e || last_key !== got.k) begin
            fails++;
            $display("FAIL %s pulse: kv=%b ke=%b last=%h, expected kv=%b ke=%b last=%h",
                     name, key_valid, key_err, last_key, got.v, got.e, got.k);
        end
        x.v = 1'b0; x.e = 1'b0; x.k = exp_last;
        sb.push_back(x);
        @(negedge clk);
        got = sb.pop_front();
        tests++;
        if (key_valid !== got.v || key_err !== got.e || last_key !== got.k) begin
            fails++;
            $display("FAIL %s after: kv=%b ke=%b last=%h, expected kv=%b ke=%b last=%h",
                     name, key_valid, key_err, last_key, got.v, got.e, got.k);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] sr [3] = '{4'b0100, 4'b1000, 4'b0000};
        logic [3:0] sc [3] = '{4'b0001, 4'b0010, 4'b0000};
        logic       se [3] = '{1'b1, 1'b1, 1'b0};
        exp_t x, got;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i > 0) begin
                got = sb.pop_front();
                tests++;
                if (key_valid !== got.v || key_err !== got.e || last_key !== got.k) begin
                    fails++;
                    $display("FAIL back_to_back step %0d: kv=%b ke=%b last=%h, expected kv=%b ke=%b last=%h",
                             i, key_valid, key_err, last_key, got.v, got.e, got.k);
                end
            end
            if (i < 3) begin
                en = se[i]; row = sr[i]; col = sc[i];
                if (se[i]) begin
                    x = expect_press(sr[i], sc[i], exp_last);
                end else begin
                    x.v = 1'b0; x.e = 1'b0; x.k = exp_last;
                end
                exp_last = x.k;
                sb.push_back(x);
            end
        end
    endtask

    task automatic test_display(input string name, input logic [6:0] exp_r, input logic [6:0] exp_l);
        logic [6:0] req;
        for (int i = 0; i < int'(P) + 2; i++) begin
            @(negedge clk);
            req = (exp_an == 2'b01) ? exp_r : (exp_an == 2'b10) ? exp_l : 7'h7F;
            tests++;
            if (an !== exp_an || seg !== req) begin
                fails++;
                $display("FAIL %s cyc %0d: an=%b seg=%h, expected an=%b seg=%h",
                         name, i, an, seg, exp_an, req);
            end
        end
    endtask

    task automatic test_all_keys(input logic [6:0] prev_in);
        logic [6:0] prev;
        logic [3:0] rr, cc, k;
        prev = prev_in;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                rr = 4'(1 << r);
                cc = 4'(1 << c);
                k  = keymap[r * 4 + c];
                test_press("all_keys", rr, cc);
                test_display("all_keys_disp", glyph[k], prev);
                prev = glyph[k];
            end
        end
    endtask

    task automatic test_reset_mid_show();
        bit found = 1'b0;
        for (int i = 0; i < int'(P) + 2 && !found; i++) begin
            @(negedge clk);
            if (an === 2'b10) found = 1'b1;
        end
        tests++;
        if (!found) begin
            fails++;
            $display("FAIL mid_reset_wait: an=%b, expected an=10 within %0d cycles", an, P + 2);
        end
        #2 reset = 1'b0;
        #1;
        tests++;
        if (an !== 2'b00 || seg !== 7'h7F) begin
            fails++;
            $display("FAIL mid_reset_async: an=%b seg=%h, expected an=00 seg=7f", an, seg);
        end
        repeat (3) @(negedge clk);
        exp_last = 4'h0;
        tests++;
        if (last_key !== 4'h0 || key_valid !== 1'b0 || key_err !== 1'b0 || an !== 2'b00) begin
            fails++;
            $display("FAIL mid_reset_hold: last=%h kv=%b ke=%b an=%b, expected last=0 kv=0 ke=0 an=00",
                     last_key, key_valid, key_err, an);
        end
        reset = 1'b1;
        test_display("post_reset", 7'h7F, 7'h7F);
    endtask

    initial begin
        test_reset();
        test_idle();
        test_press("key_2", 4'b0001, 4'b0010);
        test_display("disp_2", 7'h24, 7'h7F);
        test_press("key_D", 4'b1000, 4'b1000);
        test_display("disp_D2", 7'h21, 7'h24);
        test_press("bad_col", 4'b0100, 4'b0011);
        test_display("disp_after_err", 7'h21, 7'h24);
        test_press("zero_row", 4'b0000, 4'b0001);
        test_back_to_back();
        test_display("disp_70", 7'h40, 7'h78);
        test_press("key_5a", 4'b0010, 4'b0010);
        test_press("key_5b", 4'b0010, 4'b0010);
        test_display("disp_55", 7'h12, 7'h12);
        test_all_keys(7'h12);
        test_reset_mid_show();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
